hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_if.sv | 34 +++
 rtl/hazard_scoreboard.sv | 65 ++++++
 tb/tb_hazard_scoreboard.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// ID-stage hazard interface: the decode side drives the instruction fields,
// the scoreboard returns issue permission, forwarding selects and status.
interface hazard_if;
  logic        id_valid;
  logic [4:0]  id_rj;
  logic        id_rj_used;
  logic [4:0]  id_rk;
  logic        id_rk_used;
  logic [4:0]  id_rd;
  logic        id_ref_we;
  logic        id_dram_re;
  logic        br_flush;
  logic        id_ready_go;
  logic [1:0]  fwd_rj_sel;
  logic [1:0]  fwd_rk_sel;
  logic        exe_busy;
  logic        mem_busy;
  logic        wb_busy;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, id_rj, id_rj_used, id_rk, id_rk_used, id_rd,
           id_ref_we, id_dram_re, br_flush,
    input  id_ready_go, fwd_rj_sel, fwd_rk_sel, exe_busy, mem_busy,
           wb_busy, stall_cnt
  );

  modport slave (
    input  id_valid, id_rj, id_rj_used, id_rk, id_rk_used, id_rd,
           id_ref_we, id_dram_re, br_flush,
    output id_ready_go, fwd_rj_sel, fwd_rk_sel, exe_busy, mem_busy,
           wb_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks destination tags for EXE/MEM/WB, stalls ID on load-use and picks
// the youngest in-flight producer as the forwarding source for each operand.
module hazard_scoreboard (
  input  logic    clk,
  input  logic    rst,
  hazard_if.slave hz
);
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } tag_t;

  // index 0 = EXE, 1 = MEM, 2 = WB
  tag_t [2:0]  slot;
  tag_t        exe_next;
  logic [15:0] cnt;
  logic        load_use;
  logic        issue;

  function automatic logic hit(tag_t t, logic [4:0] r);
    return t.v && t.we && (t.rd != 5'd0) && (t.rd == r);
  endfunction

  function automatic logic [1:0] pick(tag_t [2:0] s, logic [4:0] r, logic used);
    logic [1:0] sel;
    sel = 2'd0;
    if (used) begin
      if (hit(s[0], r))      sel = 2'd1;
      else if (hit(s[1], r)) sel = 2'd2;
      else if (hit(s[2], r)) sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = slot[0].ld &&
               ((hz.id_rj_used && hit(slot[0], hz.id_rj)) ||
                (hz.id_rk_used && hit(slot[0], hz.id_rk)));
    hz.id_ready_go = !(hz.id_valid && load_use);
    issue          = hz.id_valid && hz.id_ready_go && !hz.br_flush;
    exe_next       = '0;
    if (issue) exe_next = {1'b1, hz.id_rd, hz.id_ref_we, hz.id_dram_re};
  end

  assign hz.fwd_rj_sel = pick(slot, hz.id_rj, hz.id_rj_used);
  assign hz.fwd_rk_sel = pick(slot, hz.id_rk, hz.id_rk_used);
  assign hz.exe_busy   = slot[0].v;
  assign hz.mem_busy   = slot[1].v;
  assign hz.wb_busy    = slot[2].v;
  assign hz.stall_cnt  = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
      cnt  <= '0;
    end else begin
      slot <= {slot[1], slot[0], exe_next};
      // stall counter saturates rather than wrapping
      if (hz.id_valid && !hz.id_ready_go && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed checking of hazard_scoreboard against a queue-style
// model of the three in-flight instructions.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b0;
  int   errors = 0;
  int   checks = 0;

  hazard_if hz ();
  hazard_scoreboard dut (.clk(clk), .rst(rst), .hz(hz));

  always #5 clk = ~clk;

  // model: in-flight instructions, youngest first
  logic       m_v  [3];
  logic [4:0] m_rd [3];
  logic       m_we [3];
  logic       m_ld [3];
  logic [15:0] m_cnt;

  function automatic logic m_src(int i, logic [4:0] r);
    return m_v[i] && m_we[i] && m_rd[i] != 5'd0 && m_rd[i] == r;
  endfunction

  function automatic logic [1:0] m_sel(logic [4:0] r, logic used);
    if (!used) return 2'd0;
    for (int i = 0; i < 3; i++)
      if (m_src(i, r)) return 2'(i + 1);
    return 2'd0;
  endfunction

  function automatic logic m_ready();
    logic dep;
    dep = (hz.id_rj_used && m_src(0, hz.id_rj)) ||
          (hz.id_rk_used && m_src(0, hz.id_rk));
    return !(hz.id_valid && m_ld[0] && dep);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_v[i] <= 1'b0; m_rd[i] <= 5'd0; m_we[i] <= 1'b0; m_ld[i] <= 1'b0;
      end
    end else begin
      logic ins;
      ins = hz.id_valid && m_ready() && !hz.br_flush;
      for (int i = 2; i > 0; i--) begin
        m_v[i] <= m_v[i-1]; m_rd[i] <= m_rd[i-1];
        m_we[i] <= m_we[i-1]; m_ld[i] <= m_ld[i-1];
      end
      m_v[0]  <= ins;
      m_rd[0] <= ins ? hz.id_rd : 5'd0;
      m_we[0] <= ins ? hz.id_ref_we : 1'b0;
      m_ld[0] <= ins ? hz.id_dram_re : 1'b0;
    end
  end

  always @(posedge clk or posedge rst or posedge preload) begin
    if (rst) m_cnt <= 16'd0;
    else if (preload) m_cnt <= 16'hFFFE;
    else if (hz.id_valid && !m_ready() && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("ready_go", 32'(hz.id_ready_go), 32'(m_ready()));
    check("fwd_rj", 32'(hz.fwd_rj_sel), 32'(m_sel(hz.id_rj, hz.id_rj_used)));
    check("fwd_rk", 32'(hz.fwd_rk_sel), 32'(m_sel(hz.id_rk, hz.id_rk_used)));
    check("exe_busy", 32'(hz.exe_busy), 32'(m_v[0]));
    check("mem_busy", 32'(hz.mem_busy), 32'(m_v[1]));
    check("wb_busy", 32'(hz.wb_busy), 32'(m_v[2]));
    check("stall_cnt", 32'(hz.stall_cnt), 32'(m_cnt));
  end

  task automatic set_id(logic v, logic [4:0] rj, logic rju, logic [4:0] rk, logic rku,
                        logic [4:0] rd, logic we, logic ld, logic fl);
    hz.id_valid = v; hz.id_rj = rj; hz.id_rj_used = rju; hz.id_rk = rk;
    hz.id_rk_used = rku; hz.id_rd = rd; hz.id_ref_we = we; hz.id_dram_re = ld;
    hz.br_flush = fl;
  endtask

  // present a new ID instruction just after the next rising edge
  task automatic issue(logic v, logic [4:0] rj, logic rju, logic [4:0] rk, logic rku,
                       logic [4:0] rd, logic we, logic ld, logic fl);
    @(posedge clk); #1;
    set_id(v, rj, rju, rk, rku, rd, we, ld, fl);
  endtask

  task automatic bubble();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic hold();
    @(posedge clk); #1;
  endtask

  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst_ready", 32'(hz.id_ready_go), 32'd1);
    check("rst_cnt", 32'(hz.stall_cnt), 32'd0);
    check("rst_busy", 32'({hz.exe_busy, hz.mem_busy, hz.wb_busy}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // load-use: one stall, then forward from MEM
    issue(1, 0, 0, 0, 0, 5, 1, 1, 0);
    issue(1, 5, 1, 0, 0, 9, 1, 0, 0);
    @(negedge clk);
    check("lu_stall", 32'(hz.id_ready_go), 32'd0);
    check("lu_sel_exe", 32'(hz.fwd_rj_sel), 32'd1);
    hold();
    @(negedge clk);
    check("lu_go", 32'(hz.id_ready_go), 32'd1);
    check("lu_sel_mem", 32'(hz.fwd_rj_sel), 32'd2);
    check("lu_cnt", 32'(hz.stall_cnt), 32'd1);
    repeat (3) bubble();

    // ALU back-to-back
    issue(1, 0, 0, 0, 0, 7, 1, 0, 0);
    issue(1, 7, 1, 7, 1, 8, 1, 0, 0);
    @(negedge clk);
    check("alu_go", 32'(hz.id_ready_go), 32'd1);
    check("alu_sel", 32'({hz.fwd_rj_sel, hz.fwd_rk_sel}), 32'h5);
    repeat (3) bubble();

    // priority EXE over MEM over WB
    repeat (3) issue(1, 0, 0, 0, 0, 3, 1, 0, 0);
    issue(1, 3, 1, 0, 0, 10, 1, 0, 0);
    @(negedge clk);
    check("prio_exe", 32'(hz.fwd_rj_sel), 32'd1);
    repeat (3) bubble();
    issue(1, 0, 0, 0, 0, 3, 1, 0, 0);
    bubble(); bubble();
    issue(1, 3, 1, 0, 0, 11, 1, 0, 0);
    @(negedge clk);
    check("prio_wb", 32'(hz.fwd_rj_sel), 32'd3);
    repeat (3) bubble();

    // r0 never matches; we=0 never matches
    issue(1, 0, 0, 0, 0, 0, 1, 1, 0);
    issue(1, 0, 1, 0, 1, 12, 1, 0, 0);
    @(negedge clk);
    check("r0_go", 32'(hz.id_ready_go), 32'd1);
    check("r0_sel", 32'({hz.fwd_rj_sel, hz.fwd_rk_sel}), 32'd0);
    issue(1, 0, 0, 0, 0, 4, 0, 0, 0);
    issue(1, 4, 1, 0, 0, 13, 1, 0, 0);
    @(negedge clk);
    check("nowe_sel", 32'(hz.fwd_rj_sel), 32'd0);
    repeat (3) bubble();

    // flush turns the ID instruction into a bubble
    issue(1, 0, 0, 0, 0, 9, 1, 0, 1);
    issue(1, 9, 1, 0, 0, 14, 1, 0, 0);
    @(negedge clk);
    check("fl_exe_busy", 32'(hz.exe_busy), 32'd0);
    check("fl_sel", 32'(hz.fwd_rj_sel), 32'd0);
    repeat (3) bubble();

    // saturation then asynchronous reset
    @(negedge clk); #2;
    preload = 1'b1;
    force dut.cnt = 16'hFFFE;
    #1;
    preload = 1'b0;
    release dut.cnt;
    for (int k = 0; k < 3; k++) begin
      issue(1, 0, 0, 0, 0, 5, 1, 1, 0);
      issue(1, 5, 1, 0, 0, 15, 1, 0, 0);
      hold();
    end
    @(negedge clk);
    check("sat_cnt", 32'(hz.stall_cnt), 32'hFFFF);
    issue(1, 0, 0, 0, 0, 6, 1, 0, 0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("ar_cnt", 32'(hz.stall_cnt), 32'd0);
    check("ar_busy", 32'({hz.exe_busy, hz.mem_busy, hz.wb_busy}), 32'd0);
    check("ar_ready", 32'(hz.id_ready_go), 32'd1);
    #1 rst = 1'b0;
    set_id(1, 6, 1, 6, 1, 2, 1, 0, 0);
    @(negedge clk);
    check("ar_nofwd", 32'({hz.fwd_rj_sel, hz.fwd_rk_sel}), 32'd0);

    // random traffic with a small register range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      set_id(($urandom % 8) != 0, 5'($urandom % 8), $urandom % 2,
             5'($urandom % 8), $urandom % 2, 5'($urandom % 8),
             ($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 10) == 0);
      if ($urandom % 200 == 0) begin
        rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
